// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per
// clock, LSB first, with a registered carry between digits.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       opa;
    logic [WIDTH-1:0]       opb;
    logic [WIDTH-1:0]       acc;
    logic                   cy;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;
    logic                   msb_cin;
    logic                   last;
    logic                   accept;

    assign accept = start && (state_q != S_RUN);
    assign last   = (cnt == CW'(N - 1));

    assign dsum = {1'b0, opa[DIGIT-1:0]}
                + {1'b0, opb[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, cy};

    // New digit enters from the top; after N digits the word is aligned.
    assign acc_cat  = {dsum[DIGIT-1:0], acc};
    assign acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];

    // Carry into the digit's top bit, recovered from its sum bit.
    assign msb_cin = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_RUN;
            end
            S_RUN: begin
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = accept ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa <= a;
            opb <= sub ? ~b : b;
            cy  <= sub ? ~c_in : c_in;
            cnt <= '0;
        end else if (state_q == S_RUN) begin
            opa <= opa >> DIGIT;
            opb <= opb >> DIGIT;
            acc <= acc_next;
            cy  <= dsum[DIGIT];
            cnt <= cnt + CW'(1);
            if (last) begin
                s     <= acc_next;
                c_out <= dsum[DIGIT];
                ovf   <= dsum[DIGIT] ^ msb_cin;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8/1 and 16/4 instances, vector table
// plus hand-written handshake and reset sequences.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0;
    logic        sub8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [7:0]  s8;
    logic        cout8;
    logic        ovf8;

    logic        start16 = 1'b0;
    logic        sub16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        cin16 = 1'b0;
    logic        busy16;
    logic        done16;
    logic [15:0] s16;
    logic        cout16;
    logic        ovf16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start8),
        .sub  (sub8),
        .a    (a8),
        .b    (b8),
        .c_in (cin8),
        .busy (busy8),
        .done (done8),
        .s    (s8),
        .c_out(cout8),
        .ovf  (ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start16),
        .sub  (sub16),
        .a    (a16),
        .b    (b16),
        .c_in (cin16),
        .busy (busy16),
        .done (done16),
        .s    (s16),
        .c_out(cout16),
        .ovf  (ovf16)
    );

    typedef struct {
        logic        wide;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] es;
        logic        ec;
        logic        ev;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one op; returns edges from start to done and a busy-shape flag.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        output int lat, output logic shape_ok);
        @(posedge clk);
        #1;
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = -1;
        shape_ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (busy8 && done8) shape_ok = 1'b0;
            if (done8) begin
                lat = k;
                break;
            end
            if (!busy8) shape_ok = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         output int lat, output logic shape_ok);
        @(posedge clk);
        #1;
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        lat = -1;
        shape_ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (busy16 && done16) shape_ok = 1'b0;
            if (done16) begin
                lat = k;
                break;
            end
            if (!busy16) shape_ok = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          lat;
        logic        ok;
        int          gap;
        logic        seen;

        //            wide a        b        cin   sub   s        c     v
        vecs[0]  = '{1'b0, 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'h10, 16'h20, 1'b0, 1'b1, 16'hF0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 16'h80, 16'h01, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h05, 16'h02, 1'b1, 1'b1, 16'h02, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h80, 16'h80, 1'b0, 1'b0, 16'h00, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 16'h00, 16'h00, 1'b1, 1'b0, 16'h01, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 16'h00, 16'h00, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0,
                     16'h0001, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                     16'h8000, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1,
                     16'hFFFF, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset8", {busy8, done8, s8, cout8, ovf8}, 32'h0);
        chk("reset16", {busy16, done16, s16, cout16, ovf16}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wide) begin
                run16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                      lat, ok);
                chk($sformatf("v%0d lat", i), lat, 4);
                chk($sformatf("v%0d busy", i), {31'd0, ok}, 1);
                chk($sformatf("v%0d s", i), {16'd0, s16}, {16'd0, vecs[i].es});
                chk($sformatf("v%0d cv", i), {cout16, ovf16},
                    {vecs[i].ec, vecs[i].ev});
            end else begin
                run8(vecs[i].a[7:0], vecs[i].b[7:0], vecs[i].cin,
                     vecs[i].sub, lat, ok);
                chk($sformatf("v%0d lat", i), lat, 8);
                chk($sformatf("v%0d busy", i), {31'd0, ok}, 1);
                chk($sformatf("v%0d s", i), {24'd0, s8},
                    {24'd0, vecs[i].es[7:0]});
                chk($sformatf("v%0d cv", i), {cout8, ovf8},
                    {vecs[i].ec, vecs[i].ev});
            end
        end

        // Start pulsed mid-run is ignored.
        @(posedge clk);
        #1;
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = -1;
        for (int k = 3; k < 30; k++) begin
            if (done8) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("ign lat", lat, 8);
        chk("ign s", {24'd0, s8}, 32'h7F);

        // Start in the done cycle: back-to-back, results held during RUN.
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("b2b busy", {31'd0, busy8}, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b hold s", {24'd0, s8}, 32'h7F);
        gap = -1;
        for (int k = 4; k < 30; k++) begin
            if (done8) begin
                gap = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("b2b gap", gap, 9);
        chk("b2b s", {24'd0, s8}, 32'h02);

        // Reset mid-operation.
        @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort state", {busy8, done8, s8, cout8, ovf8}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8 || busy8) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("abort no done", {31'd0, seen}, 0);
        run8(8'h01, 8'h02, 1'b0, 1'b0, lat, ok);
        chk("post lat", lat, 8);
        chk("post s", {24'd0, s8}, 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
